// File: rtl/cond_check_unit.sv
// Condition-code checker: evaluates an ARM-style condition against a snapshot
// of the NZCV flag register over a fixed three-state sequence, with saturating
// pass/fail event counters.
module cond_check_unit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       nzcv_in,
  input  logic             nzcv_we,
  input  logic [3:0]       cond,
  input  logic             req,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       nzcv_q,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e     state_q;
  logic [3:0] cond_q;
  logic [3:0] snap_q;
  logic [3:0] snap_d;
  logic       res_q;
  logic       res_d;

  // Bit order of the flag vector is {N, Z, C, V}.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n;
    logic z;
    logic cf;
    logic v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cf;
      4'h3:    r = ~cf;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cf & ~z;
      4'h9:    r = ~cf | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Snapshot sees a same-edge flag write (write-through).
  always_comb begin
    snap_d = nzcv_q;
    if (nzcv_we) begin
      snap_d = nzcv_in;
    end
    res_d = cond_eval(cond_q, snap_q);
  end

  // Flag register is writable in every FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv_q <= 4'b0000;
    end else if (nzcv_we) begin
      nzcv_q <= nzcv_in;
    end
  end

  // Sequencer: IDLE -> EVAL -> DONE -> IDLE, outputs registered on transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cond_q   <= 4'h0;
      snap_q   <= 4'h0;
      res_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            cond_q  <= cond;
            snap_q  <= snap_d;
            busy    <= 1'b1;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          res_q   <= res_d;
          state_q <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          pass    <= res_q;
          busy    <= 1'b0;
          state_q <= IDLE;
          if (res_q) begin
            if (pass_cnt != CNT_MAX) begin
              pass_cnt <= pass_cnt + CNT_W'(1);
            end
          end else begin
            if (fail_cnt != CNT_MAX) begin
              fail_cnt <= fail_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cond_check_unit.md
COND_CHECK_UNIT -- requirements
Module: cond_check_unit

Interface
REQ-001 Parameter CNT_W, default 8: width of the pass and fail event counters.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 nzcv_in  input  4  flags from the ALU, bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V.
REQ-005 nzcv_we  input  1  when high at a clock edge, nzcv_in is written into the flag register.
REQ-006 cond  input  4  condition code to evaluate; sampled only when a request is accepted.
REQ-007 req  input  1  evaluation request; accepted only in state IDLE.
REQ-008 busy  output  1  high in states EVAL and DONE.
REQ-009 done  output  1  one-cycle pulse marking that pass is valid for a new result.
REQ-010 pass  output  1  result of the most recent completed evaluation; held until the next done.
REQ-011 nzcv_q  output  4  current flag register contents.
REQ-012 pass_cnt  output  CNT_W  number of completed evaluations with pass = 1.
REQ-013 fail_cnt  output  CNT_W  number of completed evaluations with pass = 0.

Function
REQ-014 The flag register shall load nzcv_in on every clock edge with nzcv_we = 1, in any FSM state.
REQ-015 The FSM shall have exactly three states: IDLE, EVAL and DONE.
REQ-016 IDLE with req = 1 shall latch cond and snapshot the flags, then go to EVAL; IDLE with req = 0 shall stay in IDLE.
REQ-017 The flag snapshot shall be nzcv_in when nzcv_we = 1 on the accept edge, and nzcv_q otherwise (write-through).
REQ-018 EVAL shall compute the result from the latched cond and the snapshot, then go unconditionally to DONE.
REQ-019 DONE shall assert done, update pass, update the counters, then go unconditionally to IDLE.
REQ-020 Latency: req accepted at edge t gives done high during the cycle after edge t+2, and the next request can be accepted at edge t+3.
REQ-021 req shall be ignored while busy = 1; ignored requests are not queued and are not counted.
REQ-022 A flag write during EVAL or DONE shall update nzcv_q but shall not change the result in progress.
REQ-023 Condition table, code -> pass:
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 MI: N
- 5 PL: !N
- 6 VS: V
- 7 VC: !V
- 8 HI: C & !Z
- 9 LS: !C | Z
- A GE: N == V
- B LT: N != V
- C GT: !Z & (N == V)
- D LE: Z | (N != V)
- E AL: 1
- F NV: 0
REQ-024 pass_cnt shall increment by 1 on each done with pass = 1, and fail_cnt on each done with pass = 0.
REQ-025 Each counter shall saturate at 2^CNT_W - 1 and never wrap to 0.
REQ-026 No output shall depend combinationally on req, cond or nzcv_in; all outputs come from registers.

Reset
REQ-027 While reset = 1, state = IDLE and busy = 0, done = 0, pass = 0, nzcv_q = 0000, pass_cnt = 0, fail_cnt = 0, regardless of clk.
REQ-028 Reset asserted in EVAL or DONE shall abort the evaluation: no done pulse and no counter update occur.
REQ-029 After reset is released, the first rising clock edge shall be able to accept req.

Verification
REQ-030 Write nzcv_in = 0100, then issue req with cond = 0 (EQ) -> busy high for 2 cycles, one done pulse, pass = 1, pass_cnt = 1.
REQ-031 In the same edge as req with cond = A (GE), apply nzcv_we = 1 and nzcv_in = 1000 -> pass = 0 (write-through used), fail_cnt = 1.
REQ-032 Start an evaluation on flags 0010 with cond = 8 (HI), then write 0110 during EVAL -> pass = 1 and nzcv_q = 0110 afterwards.
REQ-033 Pulse req every cycle for 9 cycles with cond = E (AL) -> exactly 3 done pulses and pass_cnt = 3.
REQ-034 With CNT_W = 2, run 5 evaluations with cond = F (NV) -> fail_cnt = 3 (saturated) and pass_cnt = 0.
REQ-035 Assert reset during EVAL -> all outputs are zero immediately and no done pulse appears after release; then sweep all 16 cond codes against all 16 flag values and compare each result with REQ-023.
